stream_loader: RTL and testbench

STREAM_LOADER -- requirements
Module: stream_loader

---
 rtl/stream_loader.sv | 150 +++++++++++++++
 tb/tb_stream_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_loader.sv
// stream_loader: accepts one batch of 32-bit stream words, writes them into a
// shared BRAM as consecutive words (matrix rows first, then the vector), then
// starts the PE controller and waits for its done pulse.
//
// Optional feature: define STREAM_LOADER_CSUM_EN to get a running mod-2^32 sum
// of the accepted words on csum; otherwise csum is tied to zero.
//
// state | meaning
// IDLE  | waiting for go; word_cnt/err hold the last batch's result
// LOAD  | s_ready high, one BRAM write per accepted beat
// FLUSH | last BRAM write is on the bus; early s_last aborts from here
// START | pe_start high for this one cycle
// WAIT  | waiting for pe_done from the PE controller
module stream_loader #(
    parameter int VECTOR_SIZE = 64,
    parameter int L_RAM_SIZE  = 6
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    go,
    input  logic [31:0]             s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [31:0]             BRAM_ADDR,
    output logic [31:0]             BRAM_WRDATA,
    output logic [3:0]              BRAM_WE,
    output logic                    pe_start,
    input  logic                    pe_done,
    output logic                    busy,
    output logic                    complete,
    output logic                    err,
    output logic [L_RAM_SIZE*2:0]   word_cnt,
    output logic [31:0]             csum
);

    localparam int N  = VECTOR_SIZE * VECTOR_SIZE + VECTOR_SIZE;
    localparam int CW = L_RAM_SIZE * 2 + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_WAIT
    } state_t;

    state_t state;
    logic   abort_q;
    logic   accept;

    // s_ready is a register that is high exactly while in LOAD
    assign accept = s_valid && s_ready;

    // Batch sequencer with registered handshake, BRAM and status outputs
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= S_IDLE;
            abort_q     <= 1'b0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            BRAM_ADDR   <= 32'd0;
            BRAM_WRDATA <= 32'd0;
            BRAM_WE     <= 4'h0;
            pe_start    <= 1'b0;
            complete    <= 1'b0;
            err         <= 1'b0;
            word_cnt    <= '0;
        end else begin
            BRAM_WE  <= 4'h0;
            pe_start <= 1'b0;
            complete <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state    <= S_LOAD;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                        word_cnt <= '0;
                        err      <= 1'b0;
                        abort_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        BRAM_ADDR   <= {{(30 - CW){1'b0}}, word_cnt, 2'b00};
                        BRAM_WRDATA <= s_data;
                        BRAM_WE     <= 4'hF;
                        word_cnt    <= word_cnt + CW'(1);
                        if (word_cnt == LAST_IDX) begin
                            // Full batch: a missing s_last is flagged but the batch still runs
                            state   <= S_FLUSH;
                            s_ready <= 1'b0;
                            if (!s_last) begin
                                err <= 1'b1;
                            end
                        end else if (s_last) begin
                            // Short batch: keep the written data but never start the PEs
                            state   <= S_FLUSH;
                            s_ready <= 1'b0;
                            err     <= 1'b1;
                            abort_q <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (abort_q) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= S_START;
                        pe_start <= 1'b1;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (pe_done) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        complete <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef STREAM_LOADER_CSUM_EN
    // Running checksum of accepted words, restarted on each go
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            csum <= 32'd0;
        end else if (state == S_IDLE && go) begin
            csum <= 32'd0;
        end else if (accept) begin
            csum <= csum + s_data;
        end
    end
`else
    assign csum = 32'd0;
`endif

endmodule

// File: tb/tb_stream_loader.sv
// Self-checking bench for stream_loader at VECTOR_SIZE=4 (N=20 words).
module tb_stream_loader;

    localparam int VS = 4;
    localparam int LR = 2;
    localparam int N  = VS * VS + VS;

    logic        aclk = 1'b0;
    logic        areset;
    logic        go;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] BRAM_ADDR;
    logic [31:0] BRAM_WRDATA;
    logic [3:0]  BRAM_WE;
    logic        pe_start;
    logic        pe_done;
    logic        busy;
    logic        complete;
    logic        err;
    logic [LR*2:0] word_cnt;
    logic [31:0] csum;

    stream_loader #(.VECTOR_SIZE(VS), .L_RAM_SIZE(LR)) dut (
        .aclk(aclk), .areset(areset), .go(go),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
        .pe_start(pe_start), .pe_done(pe_done), .busy(busy), .complete(complete),
        .err(err), .word_cnt(word_cnt), .csum(csum)
    );

    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int pe_cnt, cmp_cnt, last_wr_cyc, pe_cyc, we_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock; sample #1 after the edge and log bus activity
    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
        if (BRAM_WE == 4'hF) begin
            wr_addr.push_back(BRAM_ADDR);
            wr_data.push_back(BRAM_WRDATA);
            last_wr_cyc = cyc;
        end else if (BRAM_WE !== 4'h0) begin
            we_bad++;
        end
        if (pe_start === 1'b1) begin
            pe_cnt++;
            pe_cyc = cyc;
        end
        if (complete === 1'b1) cmp_cnt++;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        pe_cnt = 0; cmp_cnt = 0; last_wr_cyc = 0; pe_cyc = 0; we_bad = 0;
    endtask

    // Reference behaviour: every beat sent lands at word index i in order;
    // a beat with s_last before index N-1 aborts (err, no start/complete);
    // a full batch without s_last on the final beat sets err but completes.
    task automatic run_batch(input string name, input int nwords, input int last_at,
                             input bit bp, input bit seq_data);
        logic [31:0] exp_q[$];
        logic [31:0] w;
        logic [31:0] sum;
        logic [31:0] exp_cs;
        bit ready_ok;
        bit exp_abort, exp_err;
        clear_mon();
        go = 1'b1; step(); go = 1'b0;
        sum = 32'd0;
        ready_ok = 1'b1;
        for (int i = 0; i < nwords; i++) begin
            if (bp && (i % 2 == 1)) begin
                s_valid = 1'b0; s_last = 1'b0; s_data = $urandom; go = 1'b1;
                step();
                go = 1'b0;
            end
            w = seq_data ? 32'(i + 1) : $urandom;
            s_valid = 1'b1; s_data = w; s_last = (i == last_at);
            if (s_ready !== 1'b1) ready_ok = 1'b0;
            step();
            exp_q.push_back(w);
            sum = sum + w;
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 32'd0;
        exp_abort = (last_at >= 0) && (last_at < N - 1);
        exp_err   = exp_abort || (last_at != N - 1);
        for (int g = 0; g < 8 && pe_cnt == 0 && busy === 1'b1; g++) step();
        if (!exp_abort) begin
            step(); step(); step();
            check({name, " busy_wait"}, 32'(busy), 32'd1);
            check({name, " no_early_cmp"}, 32'(cmp_cnt), 32'd0);
            pe_done = 1'b1; step(); pe_done = 1'b0;
            check({name, " complete_now"}, 32'(complete), 32'd1);
            step();
            check({name, " pe_after_wr"}, 32'(pe_cyc > last_wr_cyc), 32'd1);
        end else begin
            step();
            pe_done = 1'b1; step(); pe_done = 1'b0;
            step();
        end
`ifdef STREAM_LOADER_CSUM_EN
        exp_cs = sum;
`else
        exp_cs = 32'd0;
`endif
        check({name, " word_cnt"}, 32'(word_cnt), 32'(nwords));
        check({name, " err"}, 32'(err), 32'(exp_err));
        check({name, " pe_start_cnt"}, 32'(pe_cnt), exp_abort ? 32'd0 : 32'd1);
        check({name, " complete_cnt"}, 32'(cmp_cnt), exp_abort ? 32'd0 : 32'd1);
        check({name, " busy_end"}, 32'(busy), 32'd0);
        check({name, " s_ready_end"}, 32'(s_ready), 32'd0);
        check({name, " ready_in_load"}, 32'(ready_ok), 32'd1);
        check({name, " we_legal"}, 32'(we_bad), 32'd0);
        check({name, " csum"}, csum, exp_cs);
        check({name, " wr_count"}, 32'(wr_addr.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), wr_addr[i], 32'(i * 4));
            check($sformatf("%s data[%0d]", name, i), wr_data[i], exp_q[i]);
        end
    endtask

    initial begin
        areset = 1'b1; go = 1'b0; s_data = 32'd0; s_valid = 1'b0; s_last = 1'b0; pe_done = 1'b0;
        clear_mon();
        step(); step();
        check("rst s_ready", 32'(s_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst we", 32'(BRAM_WE), 32'd0);
        check("rst addr", BRAM_ADDR, 32'd0);
        check("rst wrdata", BRAM_WRDATA, 32'd0);
        check("rst pe_start", 32'(pe_start), 32'd0);
        check("rst complete", 32'(complete), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst word_cnt", 32'(word_cnt), 32'd0);
        check("rst csum", csum, 32'd0);
        areset = 1'b0;
        step();

        // pe_done while idle must be ignored
        clear_mon();
        pe_done = 1'b1; step(); pe_done = 1'b0; step();
        check("idle pe_done cmp", 32'(cmp_cnt), 32'd0);
        check("idle pe_done busy", 32'(busy), 32'd0);

        run_batch("nominal", N, N - 1, 1'b0, 1'b1);
        run_batch("backpressure", N, N - 1, 1'b1, 1'b0);
        run_batch("early_last", 7, 6, 1'b0, 1'b0);
        run_batch("missing_last", N, -1, 1'b0, 1'b0);

        // Reset in the middle of a batch, while a write is on the bus
        clear_mon();
        go = 1'b1; step(); go = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
            step();
        end
        check("midrst we_before", 32'(BRAM_WE), 32'hF);
        #2;
        areset = 1'b1;
        #1;
        check("midrst we", 32'(BRAM_WE), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst s_ready", 32'(s_ready), 32'd0);
        check("midrst word_cnt", 32'(word_cnt), 32'd0);
        check("midrst addr", BRAM_ADDR, 32'd0);
        check("midrst wrdata", BRAM_WRDATA, 32'd0);
        check("midrst csum", csum, 32'd0);
        check("midrst err", 32'(err), 32'd0);
        check("midrst pe_start", 32'(pe_start), 32'd0);
        s_valid = 1'b0; s_data = 32'd0;
        step(); step();
        areset = 1'b0;
        step();
        run_batch("post_reset", N, N - 1, 1'b0, 1'b1);

        // Randomised batches of mixed kinds
        for (int r = 0; r < 4; r++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                run_batch($sformatf("rand%0d_nom", r), N, N - 1, 1'($urandom_range(0, 1)), 1'b0);
            end else if (kind == 1) begin
                len = $urandom_range(1, N - 1);
                run_batch($sformatf("rand%0d_early", r), len, len - 1, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                run_batch($sformatf("rand%0d_miss", r), N, -1, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
